xs3_seq_ctrl: RTL and testbench

XS3_SEQ_CTRL -- requirements
Module: xs3_seq_ctrl

---
 rtl/xs3_seq_ctrl.sv | 85 ++++++++
 tb/tb_xs3_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xs3_seq_ctrl.sv
// rtl/xs3_seq_ctrl.sv - sequential BCD to excess-3 converter, one digit per clock
module xs3_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_xs3,
    output logic [NDIG-1:0]   out_err,
    output logic              out_any_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [4*NDIG-1:0]   word;
    logic [3:0]          digit;
    logic [3:0]          nib;
    logic                inv;

    // Single shared converter, fed by the digit currently addressed by idx
    assign digit = word[4*idx +: 4];
    assign inv   = digit[3] & (digit[2] | digit[1]);
    assign nib   = inv ? 4'h0 : digit + 4'd3;

    assign in_ready    = (state == IDLE) && !rst;
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_any_err = |out_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            word    <= '0;
            out_xs3 <= '0;
            out_err <= '0;
            err_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word    <= in_bcd;
                        idx     <= '0;
                        out_xs3 <= '0;
                        out_err <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    out_xs3[4*idx +: 4] <= nib;
                    out_err[idx]        <= inv;
                    if (idx == IW'(NDIG - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (out_any_err && (err_cnt != 8'hFF))
                            err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_seq_ctrl.sv
// tb/tb_xs3_seq_ctrl.sv - self-checking bench for xs3_seq_ctrl against a word-level model
module tb_xs3_seq_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           r_rst = 1'b1;
    logic           r_iv = 1'b0;
    logic [4*N-1:0] r_bcd = '0;
    logic           r_ordy = 1'b0;

    logic           in_ready;
    logic           out_valid;
    logic [4*N-1:0] out_xs3;
    logic [N-1:0]   out_err;
    logic           out_any_err;
    logic           busy;
    logic [7:0]     err_cnt;

    xs3_seq_ctrl #(.NDIG(N)) dut (
        .clk        (clk),
        .rst        (r_rst),
        .in_valid   (r_iv),
        .in_ready   (in_ready),
        .in_bcd     (r_bcd),
        .out_valid  (out_valid),
        .out_ready  (r_ordy),
        .out_xs3    (out_xs3),
        .out_err    (out_err),
        .out_any_err(out_any_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Word-level model: activity flag plus edges elapsed since acceptance
    bit             m_active = 1'b0;
    int             m_count  = 0;
    logic [4*N-1:0] m_word   = '0;
    logic [4*N-1:0] m_xs3    = '0;
    logic [N-1:0]   m_err    = '0;
    int             m_ecnt   = 0;
    int             m_delivered = 0;

    function automatic logic [4*N-1:0] ref_xs3(input logic [4*N-1:0] w);
        logic [4*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = int'(w[4*i +: 4]);
            r[4*i +: 4] = (d > 9) ? 4'h0 : 4'((d + 3) % 16);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] ref_err(input logic [4*N-1:0] w);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (int'(w[4*i +: 4]) > 9);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (r_rst) begin
            m_active = 1'b0;
            m_xs3    = '0;
            m_err    = '0;
            m_ecnt   = 0;
        end else if (!m_active) begin
            if (r_iv) begin
                m_active = 1'b1;
                m_count  = 0;
                m_word   = r_bcd;
            end
        end else if (m_count < N) begin
            m_count++;
            if (m_count == N) begin
                m_xs3 = ref_xs3(m_word);
                m_err = ref_err(m_word);
            end
        end else if (r_ordy) begin
            m_active = 1'b0;
            m_delivered++;
            if ((m_err != 0) && (m_ecnt < 255)) m_ecnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit mv;
            mv = m_active && (m_count >= N);
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("busy", 32'(busy), 32'(m_active));
            chk("in_ready", 32'(in_ready), 32'(!m_active && !r_rst));
            chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
            if (!m_active || mv) begin
                chk("out_xs3", 32'(out_xs3), 32'(m_xs3));
                chk("out_err", 32'(out_err), 32'(m_err));
                chk("out_any_err", 32'(out_any_err), 32'(m_err != 0));
            end
        end
    end

    // Send one word, check latency, hold out_ready low for 'hold' cycles in DONE
    task automatic run_word(input logic [4*N-1:0] w, input int hold);
        int n;
        r_iv = 1'b1; r_bcd = w; r_ordy = 1'b0;
        n = 0;
        while (!m_active && n < 10) begin step(); n++; end
        if (!m_active) begin
            checks++; errors++;
            $display("FAIL accept_timeout word=%0h", w);
            r_iv = 1'b0;
            return;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            r_iv = 1'($urandom); r_bcd = 16'($urandom); r_ordy = 1'($urandom);
            step(); n++;
        end
        chk("latency", 32'(n), 32'(N));
        for (int k = 0; k < hold; k++) begin
            r_ordy = 1'b0; r_iv = 1'b1; r_bcd = 16'($urandom);
            step();
        end
        r_ordy = 1'b1; r_iv = 1'b0;
        step();
        r_ordy = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_word(input bit force_bad);
        logic [4*N-1:0] w;
        w = 16'($urandom);
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0) w[4*i +: 4] = 4'($urandom_range(0, 9));
        if (force_bad) w[4*$urandom_range(0, N-1) +: 4] = 4'hF;
        return w;
    endfunction

    initial begin
        // Pin the model with hand-computed values
        chk("model_1234", 32'(ref_xs3(16'h1234)), 32'h4567);
        chk("model_9A05", 32'(ref_xs3(16'h9A05)), 32'hC038);
        chk("model_9A05_err", 32'(ref_err(16'h9A05)), 32'b0100);
        chk("model_9999", 32'(ref_xs3(16'h9999)), 32'hCCCC);

        r_rst = 1'b1;
        step(); step();
        r_rst = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_xs3", 32'(out_xs3), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        run_word(16'h1234, 0);
        chk("basic_xs3", 32'(out_xs3), 32'h4567);
        chk("basic_err_cnt", 32'(err_cnt), 32'd0);

        run_word(16'h9A05, 0);
        chk("inv_xs3", 32'(out_xs3), 32'hC038);
        chk("inv_err", 32'(out_err), 32'b0100);
        chk("inv_err_cnt", 32'(err_cnt), 32'd1);

        run_word(16'h4321, 5);
        chk("bp_handoff_ready", 32'(in_ready), 32'd1);

        // Abort after two conversion edges
        r_iv = 1'b1; r_bcd = 16'h5678;
        step();
        r_iv = 1'b0;
        step(); step();
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_xs3", 32'(out_xs3), 32'd0);
        chk("abort_err_cnt", 32'(err_cnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 8; k++) step();

        run_word(16'h0000, 0);
        chk("b2b_0000", 32'(out_xs3), 32'h3333);
        run_word(16'h9999, 0);
        chk("b2b_9999", 32'(out_xs3), 32'hCCCC);

        for (int k = 0; k < 40; k++)
            run_word(rand_word(1'b0), $urandom_range(0, 3));

        for (int k = 0; k < 260; k++)
            run_word(rand_word(1'b1), $urandom_range(0, 1));
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("delivered", 32'(m_delivered), 32'd305);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
